// File: rtl/pipelined_dual_port_ram_pkg.sv
// Shared types, constants and helpers for the pipelined dual-port RAM.
package ram_pkg;

  localparam int unsigned COLLISION_READ_OLD      = 0;
  localparam int unsigned COLLISION_WRITE_THROUGH = 1;

  // Upper bound on word width handled by byte_merge; callers zero-extend into it.
  localparam int unsigned MAX_DATA_WIDTH = 1024;
  localparam int unsigned MAX_IDX_W      = $clog2(MAX_DATA_WIDTH);

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } ram_state_t;

  function automatic int unsigned lane_count(input int unsigned data_width,
                                             input int unsigned byte_width);
    return data_width / byte_width;
  endfunction

  function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
    input logic [MAX_DATA_WIDTH-1:0] old_word,
    input logic [MAX_DATA_WIDTH-1:0] new_word,
    input logic [MAX_DATA_WIDTH-1:0] lane_en,
    input int unsigned               byte_width
  );
    logic [MAX_DATA_WIDTH-1:0] merged;
    logic [MAX_IDX_W-1:0]      lane;
    logic [MAX_IDX_W-1:0]      bit_idx;
    merged = old_word;
    for (int unsigned i = 0; i < MAX_DATA_WIDTH; i++) begin
      lane    = MAX_IDX_W'(i / byte_width);
      bit_idx = MAX_IDX_W'(i);
      if (lane_en[lane]) merged[bit_idx] = new_word[bit_idx];
    end
    return merged;
  endfunction

endpackage

// File: rtl/pipelined_dual_port_ram_read_pipe.sv
// Response delay line: LATENCY register stages carrying valid/err/data, flushed by reset.
module ram_read_pipe #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_err,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_err
);

  logic                  valid_q [LATENCY];
  logic                  err_q   [LATENCY];
  logic [DATA_WIDTH-1:0] data_q  [LATENCY];

  // Data only advances with a valid token, so the last stage holds between responses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q[0] <= 1'b0;
      err_q[0]   <= 1'b0;
      data_q[0]  <= '0;
    end else begin
      valid_q[0] <= in_valid;
      err_q[0]   <= in_valid & in_err;
      if (in_valid) data_q[0] <= in_data;
    end
  end

  for (genvar i = 1; i < LATENCY; i++) begin : g_stage
    always_ff @(posedge clk) begin
      if (!reset) begin
        valid_q[i] <= 1'b0;
        err_q[i]   <= 1'b0;
        data_q[i]  <= '0;
      end else begin
        valid_q[i] <= valid_q[i-1];
        err_q[i]   <= valid_q[i-1] & err_q[i-1];
        if (valid_q[i-1]) data_q[i] <= data_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[LATENCY-1];
  assign out_err   = err_q[LATENCY-1];
  assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/pipelined_dual_port_ram.sv
// Dual-port RAM: port A read/write with byte lanes, port B read-only, pipelined
// responses, collision policy, range checking and a post-reset clear sequencer.
module pipelined_dual_port_ram
  import ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned BYTE_WIDTH     = 8,
  parameter int unsigned ADDRESS_WIDTH  = 32,
  parameter int unsigned DEPTH          = 512,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned COLLISION_MODE = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         reqA,
  input  logic                                         weA,
  input  logic [ADDRESS_WIDTH-1:0]                     addrA,
  input  logic [DATA_WIDTH-1:0]                        dataInA,
  input  logic [lane_count(DATA_WIDTH, BYTE_WIDTH)-1:0] byteEnA,
  output logic [DATA_WIDTH-1:0]                        outA,
  output logic                                         validA,
  output logic                                         errA,
  input  logic                                         reqB,
  input  logic [ADDRESS_WIDTH-1:0]                     addrB,
  output logic [DATA_WIDTH-1:0]                        outB,
  output logic                                         validB,
  output logic                                         errB,
  output logic                                         busy
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so the range check never wraps, whatever ADDRESS_WIDTH is.
  localparam logic [ADDRESS_WIDTH:0] DEPTH_EXT = (ADDRESS_WIDTH + 1)'(DEPTH);

  ram_state_t            state;
  logic [IDX_W-1:0]      clear_addr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  ready;
  logic                  accept_a;
  logic                  accept_b;
  logic                  in_range_a;
  logic                  in_range_b;
  logic                  write_a;
  logic [IDX_W-1:0]      idx_a;
  logic [IDX_W-1:0]      idx_b;
  logic [DATA_WIDTH-1:0] word_a;
  logic [DATA_WIDTH-1:0] word_b;
  logic [DATA_WIDTH-1:0] merged_a;
  logic [DATA_WIDTH-1:0] resp_a;
  logic [DATA_WIDTH-1:0] resp_b;

  assign ready      = (state == ST_READY) && reset;
  assign busy       = !ready;
  assign accept_a   = reqA && ready;
  assign accept_b   = reqB && ready;
  assign in_range_a = {1'b0, addrA} < DEPTH_EXT;
  assign in_range_b = {1'b0, addrB} < DEPTH_EXT;
  assign idx_a      = addrA[IDX_W-1:0];
  assign idx_b      = addrB[IDX_W-1:0];
  assign write_a    = accept_a && weA && in_range_a;
  assign word_a     = mem[idx_a];
  assign word_b     = mem[idx_b];

  always_comb begin
    merged_a = DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(word_a), MAX_DATA_WIDTH'(dataInA),
                                      MAX_DATA_WIDTH'(byteEnA), BYTE_WIDTH));
    resp_a = '0;
    resp_b = '0;
    if (in_range_a) resp_a = weA ? merged_a : word_a;
    if (in_range_b) begin
      if (COLLISION_MODE == COLLISION_WRITE_THROUGH && write_a && idx_a == idx_b)
        resp_b = merged_a;
      else
        resp_b = word_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      clear_addr <= '0;
    end else if (state == ST_CLEAR) begin
      clear_addr <= clear_addr + IDX_W'(1);
      if (clear_addr == IDX_W'(DEPTH - 1)) state <= ST_READY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && state == ST_CLEAR) mem[clear_addr] <= '0;
    else if (write_a)               mem[idx_a]      <= merged_a;
  end

  ram_read_pipe #(
    .DATA_WIDTH(DATA_WIDTH),
    .LATENCY   (READ_LATENCY)
  ) u_pipe_a (
    .clk      (clk),
    .reset    (reset),
    .in_valid (accept_a),
    .in_data  (resp_a),
    .in_err   (!in_range_a),
    .out_valid(validA),
    .out_data (outA),
    .out_err  (errA)
  );

  ram_read_pipe #(
    .DATA_WIDTH(DATA_WIDTH),
    .LATENCY   (READ_LATENCY)
  ) u_pipe_b (
    .clk      (clk),
    .reset    (reset),
    .in_valid (accept_b),
    .in_data  (resp_b),
    .in_err   (!in_range_b),
    .out_valid(validB),
    .out_data (outB),
    .out_err  (errB)
  );

endmodule

// File: tb/tb_pipelined_dual_port_ram.sv
// Directed bench: dut0 = latency 1 / read-old collisions, dut1 = latency 2 / write-through.
module tb_pipelined_dual_port_ram;

  localparam int unsigned DEPTH = 512;

  logic        clk = 1'b0;
  logic        reset;
  logic        reqA, weA, reqB;
  logic [31:0] addrA, addrB, dataInA;
  logic [3:0]  byteEnA;

  logic [31:0] outA0, outB0, outA1, outB1;
  logic        validA0, errA0, validB0, errB0, busy0;
  logic        validA1, errA1, validB1, errB1, busy1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipelined_dual_port_ram #(
    .READ_LATENCY  (1),
    .COLLISION_MODE(0)
  ) u_dut0 (
    .clk(clk), .reset(reset), .reqA(reqA), .weA(weA), .addrA(addrA), .dataInA(dataInA),
    .byteEnA(byteEnA), .outA(outA0), .validA(validA0), .errA(errA0), .reqB(reqB),
    .addrB(addrB), .outB(outB0), .validB(validB0), .errB(errB0), .busy(busy0)
  );

  pipelined_dual_port_ram #(
    .READ_LATENCY  (2),
    .COLLISION_MODE(1)
  ) u_dut1 (
    .clk(clk), .reset(reset), .reqA(reqA), .weA(weA), .addrA(addrA), .dataInA(dataInA),
    .byteEnA(byteEnA), .outA(outA1), .validA(validA1), .errA(errA1), .reqB(reqB),
    .addrB(addrB), .outB(outB1), .validB(validB1), .errB(errB1), .busy(busy1)
  );

  task automatic set_idle();
    reqA = 1'b0; weA = 1'b0; reqB = 1'b0;
    addrA = '0; addrB = '0; dataInA = '0; byteEnA = '0;
  endtask

  task automatic drive_a(input logic we, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] en);
    reqA = 1'b1; weA = we; addrA = addr; dataInA = data; byteEnA = en;
  endtask

  task automatic drive_b(input logic [31:0] addr);
    reqB = 1'b1; addrB = addr;
  endtask

  task automatic test_reset();
    set_idle();
    drive_a(1'b1, 32'd0, 32'hFFFF_FFFF, 4'hF);
    drive_b(32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
      errors++; $display("FAIL reset_busy: got %b/%b expected 1/1", busy0, busy1);
    end
    checks++;
    if ({validA0, validB0, validA1, validB1} !== 4'b0000) begin
      errors++; $display("FAIL reset_valid: got %b expected 0000", {validA0, validB0, validA1, validB1});
    end
    checks++;
    if ({errA0, errB0, errA1, errB1} !== 4'b0000) begin
      errors++; $display("FAIL reset_err: got %b expected 0000", {errA0, errB0, errA1, errB1});
    end
    checks++;
    if (outA0 !== 32'd0 || outB0 !== 32'd0 || outA1 !== 32'd0 || outB1 !== 32'd0) begin
      errors++; $display("FAIL reset_out: got %h %h %h %h expected 0", outA0, outB0, outA1, outB1);
    end
    set_idle();
  endtask

  task automatic test_clear();
    int unsigned cycles;
    int unsigned bad;
    reset = 1'b1;
    cycles = 0;
    while (busy0 === 1'b1 && cycles < 2000) begin
      cycles++;
      @(negedge clk);
    end
    checks++;
    if (cycles != DEPTH) begin
      errors++; $display("FAIL clear_busy_cycles: got %0d expected %0d", cycles, DEPTH);
    end
    checks++;
    if (busy1 !== 1'b0) begin
      errors++; $display("FAIL clear_busy1_done: got %b expected 0", busy1);
    end
    bad = 0;
    for (int unsigned i = 0; i < DEPTH + 2; i++) begin
      if (i >= 1 && i <= DEPTH &&
          (validA0 !== 1'b1 || validB0 !== 1'b1 || outA0 !== 32'd0 || outB0 !== 32'd0 ||
           errA0 !== 1'b0 || errB0 !== 1'b0)) bad++;
      if (i >= 2 &&
          (validA1 !== 1'b1 || validB1 !== 1'b1 || outA1 !== 32'd0 || outB1 !== 32'd0 ||
           errA1 !== 1'b0 || errB1 !== 1'b0)) bad++;
      if (i < DEPTH) begin
        drive_a(1'b0, i, 32'd0, 4'h0);
        drive_b(i);
      end else begin
        set_idle();
      end
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL clear_readback: bad responses %0d expected 0", bad);
    end
  endtask

  task automatic test_byte_enable();
    drive_a(1'b1, 32'd5, 32'hAABB_CCDD, 4'hF);
    @(negedge clk);
    checks++;
    if (validA0 !== 1'b1 || outA0 !== 32'hAABB_CCDD || errA0 !== 1'b0) begin
      errors++; $display("FAIL be_full_a0: got v=%b %h expected v=1 aabbccdd", validA0, outA0);
    end
    drive_a(1'b1, 32'd5, 32'h1122_3344, 4'b0101);
    @(negedge clk);
    checks++;
    if (validA1 !== 1'b1 || outA1 !== 32'hAABB_CCDD) begin
      errors++; $display("FAIL be_full_a1: got v=%b %h expected v=1 aabbccdd", validA1, outA1);
    end
    checks++;
    if (validA0 !== 1'b1 || outA0 !== 32'hAA22_CC44) begin
      errors++; $display("FAIL be_partial_a0: got v=%b %h expected v=1 aa22cc44", validA0, outA0);
    end
    set_idle();
    drive_a(1'b1, 32'd5, 32'hDEAD_BEEF, 4'h0);
    drive_b(32'd5);
    @(negedge clk);
    checks++;
    if (validA1 !== 1'b1 || outA1 !== 32'hAA22_CC44) begin
      errors++; $display("FAIL be_partial_a1: got v=%b %h expected v=1 aa22cc44", validA1, outA1);
    end
    checks++;
    if (validB0 !== 1'b1 || outB0 !== 32'hAA22_CC44) begin
      errors++; $display("FAIL be_read_b0: got v=%b %h expected v=1 aa22cc44", validB0, outB0);
    end
    checks++;
    if (validA0 !== 1'b1 || outA0 !== 32'hAA22_CC44) begin
      errors++; $display("FAIL be_noop_a0: got v=%b %h expected v=1 aa22cc44", validA0, outA0);
    end
    set_idle();
    @(negedge clk);
    checks++;
    if (validB1 !== 1'b1 || outB1 !== 32'hAA22_CC44 || outA1 !== 32'hAA22_CC44) begin
      errors++; $display("FAIL be_read_b1: got v=%b %h a=%h expected v=1 aa22cc44", validB1, outB1, outA1);
    end
    checks++;
    if (validA0 !== 1'b0 || errA0 !== 1'b0 || outA0 !== 32'hAA22_CC44) begin
      errors++; $display("FAIL be_hold_a0: got v=%b e=%b %h expected v=0 e=0 aa22cc44", validA0, errA0, outA0);
    end
    @(negedge clk);
  endtask

  task automatic test_latency();
    logic        exp_v;
    logic [31:0] exp_d;
    for (int unsigned i = 1; i <= 3; i++) begin
      drive_a(1'b1, i, i, 4'hF);
      @(negedge clk);
    end
    set_idle();
    repeat (2) @(negedge clk);
    for (int unsigned k = 0; k < 6; k++) begin
      if (k >= 1) begin
        exp_v = (k <= 3);
        exp_d = (k <= 3) ? 32'(k) : 32'd3;
        checks++;
        if (validB0 !== exp_v || outB0 !== exp_d) begin
          errors++; $display("FAIL lat1_b0 k=%0d: got v=%b %h expected v=%b %h", k, validB0, outB0, exp_v, exp_d);
        end
      end
      if (k >= 2) begin
        exp_v = (k <= 4);
        exp_d = (k <= 4) ? 32'(k - 1) : 32'd3;
        checks++;
        if (validB1 !== exp_v || outB1 !== exp_d) begin
          errors++; $display("FAIL lat2_b1 k=%0d: got v=%b %h expected v=%b %h", k, validB1, outB1, exp_v, exp_d);
        end
      end
      if (k < 3) drive_b(32'(k + 1));
      else       set_idle();
      @(negedge clk);
    end
  endtask

  task automatic test_collision();
    drive_a(1'b1, 32'd9, 32'd0, 4'hF);
    @(negedge clk);
    set_idle();
    @(negedge clk);
    drive_a(1'b1, 32'd9, 32'hFFFF_FFFF, 4'hF);
    drive_b(32'd9);
    @(negedge clk);
    checks++;
    if (validB0 !== 1'b1 || outB0 !== 32'd0 || outA0 !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL coll_old_b0: got v=%b b=%h a=%h expected v=1 b=0 a=ffffffff", validB0, outB0, outA0);
    end
    drive_a(1'b1, 32'd9, 32'h1234_5678, 4'b0011);
    drive_b(32'd9);
    @(negedge clk);
    checks++;
    if (validB1 !== 1'b1 || outB1 !== 32'hFFFF_FFFF || outA1 !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL coll_new_b1: got v=%b b=%h a=%h expected v=1 ffffffff", validB1, outB1, outA1);
    end
    checks++;
    if (outB0 !== 32'hFFFF_FFFF || outA0 !== 32'hFFFF_5678) begin
      errors++; $display("FAIL coll_partial_b0: got b=%h a=%h expected b=ffffffff a=ffff5678", outB0, outA0);
    end
    set_idle();
    @(negedge clk);
    checks++;
    if (validB1 !== 1'b1 || outB1 !== 32'hFFFF_5678 || outA1 !== 32'hFFFF_5678) begin
      errors++; $display("FAIL coll_partial_b1: got b=%h a=%h expected ffff5678", outB1, outA1);
    end
    @(negedge clk);
  endtask

  task automatic test_out_of_range();
    drive_a(1'b1, 32'd511, 32'hCAFE_F00D, 4'hF);
    @(negedge clk);
    checks++;
    if (validA0 !== 1'b1 || errA0 !== 1'b0 || outA0 !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL oor_last_addr: got v=%b e=%b %h expected v=1 e=0 cafef00d", validA0, errA0, outA0);
    end
    drive_a(1'b1, 32'd512, 32'h0000_1234, 4'hF);
    drive_b(32'h8000_0000);
    @(negedge clk);
    checks++;
    if (validA0 !== 1'b1 || errA0 !== 1'b1 || outA0 !== 32'd0) begin
      errors++; $display("FAIL oor_a0: got v=%b e=%b %h expected v=1 e=1 0", validA0, errA0, outA0);
    end
    checks++;
    if (validB0 !== 1'b1 || errB0 !== 1'b1 || outB0 !== 32'd0) begin
      errors++; $display("FAIL oor_b0: got v=%b e=%b %h expected v=1 e=1 0", validB0, errB0, outB0);
    end
    set_idle();
    drive_a(1'b0, 32'd0, 32'd0, 4'h0);
    drive_b(32'd0);
    @(negedge clk);
    checks++;
    if (validA1 !== 1'b1 || errA1 !== 1'b1 || outA1 !== 32'd0 ||
        validB1 !== 1'b1 || errB1 !== 1'b1 || outB1 !== 32'd0) begin
      errors++; $display("FAIL oor_dut1: got a=%b%b %h b=%b%b %h expected 11 0", validA1, errA1, outA1, validB1, errB1, outB1);
    end
    checks++;
    if (validA0 !== 1'b1 || errA0 !== 1'b0 || outA0 !== 32'd0 || errB0 !== 1'b0 || outB0 !== 32'd0) begin
      errors++; $display("FAIL oor_no_alias0: got v=%b e=%b a=%h b=%h expected v=1 e=0 0 0", validA0, errA0, outA0, outB0);
    end
    set_idle();
    @(negedge clk);
    checks++;
    if (validA1 !== 1'b1 || errA1 !== 1'b0 || outA1 !== 32'd0 || outB1 !== 32'd0) begin
      errors++; $display("FAIL oor_no_alias1: got v=%b e=%b a=%h b=%h expected v=1 e=0 0 0", validA1, errA1, outA1, outB1);
    end
    checks++;
    if (validA0 !== 1'b0 || errA0 !== 1'b0 || errB0 !== 1'b0) begin
      errors++; $display("FAIL oor_err_clears: got v=%b eA=%b eB=%b expected 0 0 0", validA0, errA0, errB0);
    end
  endtask

  task automatic test_reset_mid_request();
    drive_b(32'd5);
    @(negedge clk);
    checks++;
    if (validB0 !== 1'b1 || outB0 !== 32'hAA22_CC44) begin
      errors++; $display("FAIL midreq_b0: got v=%b %h expected v=1 aa22cc44", validB0, outB0);
    end
    reset = 1'b0;
    set_idle();
    @(negedge clk);
    checks++;
    if (validB1 !== 1'b0 || outB1 !== 32'd0 || busy0 !== 1'b1) begin
      errors++; $display("FAIL midreq_flush: got v=%b %h busy=%b expected v=0 0 busy=1", validB1, outB1, busy0);
    end
  endtask

  task automatic test_reset_mid_clear();
    int unsigned cycles;
    int unsigned saw_valid;
    saw_valid = 0;
    reset = 1'b1;
    drive_b(32'd3);
    for (int unsigned i = 0; i < 100; i++) begin
      @(negedge clk);
      if (validB0 !== 1'b0 || validB1 !== 1'b0 || busy0 !== 1'b1) saw_valid++;
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    cycles = 0;
    while (busy0 === 1'b1 && cycles < 2000) begin
      if (validB0 !== 1'b0 || validB1 !== 1'b0) saw_valid++;
      cycles++;
      @(negedge clk);
    end
    set_idle();
    checks++;
    if (cycles != DEPTH) begin
      errors++; $display("FAIL midclear_busy_cycles: got %0d expected %0d", cycles, DEPTH);
    end
    checks++;
    if (saw_valid != 0) begin
      errors++; $display("FAIL midclear_no_valid: got %0d bad cycles expected 0", saw_valid);
    end
    drive_a(1'b0, 32'd5, 32'd0, 4'h0);
    drive_b(32'd511);
    @(negedge clk);
    set_idle();
    checks++;
    if (validA0 !== 1'b1 || outA0 !== 32'd0 || validB0 !== 1'b1 || outB0 !== 32'd0) begin
      errors++; $display("FAIL midclear_zeroed: got a=%b %h b=%b %h expected 1 0 1 0", validA0, outA0, validB0, outB0);
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    set_idle();
    test_reset();
    test_clear();
    test_byte_enable();
    test_latency();
    test_collision();
    test_out_of_range();
    test_reset_mid_request();
    test_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
